// File: rtl/ntsc_line_sequencer_if.sv
// Configuration handshake bundle for ntsc_line_sequencer.
// The master drives cfg_valid with the payload (cfg_lines, cfg_hue, cfg_burst_en).
// The slave returns cfg_ready.
interface ntsc_line_sequencer_if;
    localparam int unsigned LINES_W = 9;
    localparam int unsigned HUE_W   = 5;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [LINES_W-1:0] cfg_lines;
    logic [HUE_W-1:0]   cfg_hue;
    logic               cfg_burst_en;

    modport master (
        output cfg_valid,
        output cfg_lines,
        output cfg_hue,
        output cfg_burst_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_lines,
        input  cfg_hue,
        input  cfg_burst_en,
        output cfg_ready
    );
endinterface

// File: rtl/ntsc_line_sequencer.sv
// NTSC line/frame timing sequencer.
// It generates the sync, burst gate, active window and line/frame strobes
// from free-running horizontal and vertical counters.
// A new frame configuration is taken over the cfg handshake. It is held
// pending and made live only at the end of the current frame.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   color_phase       pixel hue phase (5b)
//   cfg               slave side of the config handshake (lines/hue/burst_en)
//   sync_n            composite sync, low active (normal or broad)
//   burst_gate        colour burst window
//   active            active picture window
//   line_start        one-cycle strobe at h_count==0
//   frame_start       one-cycle strobe at h_count==0, v_count==0
//   select            phase-generator select, (color_phase+hue) mod 32 in active
//   line_num          v_count that produced this cycle's outputs
// All outputs are registered with one cycle of latency from the counters.
module ntsc_line_sequencer #(
    parameter int unsigned LINE_LEN    = 7280,
    parameter int unsigned SYNC_LEN    = 538,
    parameter int unsigned BURST_START = 607,
    parameter int unsigned BURST_LEN   = 288,
    parameter int unsigned ACT_START   = 1240,
    parameter int unsigned ACT_END     = 7000,
    parameter int unsigned VSYNC_LINES = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [4:0]                  color_phase,
    ntsc_line_sequencer_if.slave        cfg,
    output logic                        sync_n,
    output logic                        burst_gate,
    output logic                        active,
    output logic                        line_start,
    output logic                        frame_start,
    output logic [4:0]                  select,
    output logic [8:0]                  line_num
);
    localparam int unsigned HW = 13;
    localparam int unsigned VW = 9;
    localparam int unsigned PW = 5;

    localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_SYNC    = HW'(SYNC_LEN);
    localparam logic [HW-1:0] H_BROAD   = HW'(LINE_LEN - SYNC_LEN);
    localparam logic [HW-1:0] H_BURST_S = HW'(BURST_START);
    localparam logic [HW-1:0] H_BURST_E = HW'(BURST_START + BURST_LEN);
    localparam logic [HW-1:0] H_ACT_S   = HW'(ACT_START);
    localparam logic [HW-1:0] H_ACT_E   = HW'(ACT_END);
    localparam logic [VW-1:0] V_SYNC    = VW'(VSYNC_LINES);
    localparam logic [VW-1:0] V_MIN     = VW'(VSYNC_LINES + 1);
    localparam logic [VW-1:0] V_DEFAULT = VW'(262);

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;

    logic [VW-1:0] lines_live;
    logic [PW-1:0] hue_live;
    logic          burst_live;
    logic          pend_valid;
    logic [VW-1:0] pend_lines;
    logic [PW-1:0] pend_hue;
    logic          pend_burst;
    logic          ready_q;

    logic          line_end_c;
    logic          frame_end_c;
    logic          transfer_c;
    logic          vsync_line_c;
    logic          sync_low_c;
    logic          burst_c;
    logic          active_c;
    logic [VW-1:0] lines_clamped_c;

    assign cfg.cfg_ready = ready_q;

    // Decode of the current counter position; feeds the registered outputs.
    // ">=" on the frame end keeps v_count bounded even if lines ever shrinks below it.
    always_comb begin
        line_end_c      = (h_count == H_LAST);
        frame_end_c     = line_end_c && (v_count >= (lines_live - VW'(1)));
        transfer_c      = cfg.cfg_valid && ready_q;
        vsync_line_c    = (v_count < V_SYNC);
        sync_low_c      = vsync_line_c ? (h_count < H_BROAD) : (h_count < H_SYNC);
        burst_c         = burst_live && !vsync_line_c &&
                          (h_count >= H_BURST_S) && (h_count < H_BURST_E);
        active_c        = !vsync_line_c && (h_count >= H_ACT_S) && (h_count < H_ACT_E);
        lines_clamped_c = (cfg.cfg_lines < V_MIN) ? V_MIN : cfg.cfg_lines;
    end

    // Horizontal / vertical counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else begin
            h_count <= line_end_c ? '0 : h_count + HW'(1);
            if (line_end_c) begin
                v_count <= frame_end_c ? '0 : v_count + VW'(1);
            end
        end
    end

    // Config handshake: capture into pending, promote to live at frame end.
    // A transfer landing on the frame-end clock can only happen with nothing
    // pending, so it waits for the following frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            lines_live <= V_DEFAULT;
            hue_live   <= '0;
            burst_live <= 1'b1;
            pend_valid <= 1'b0;
            pend_lines <= '0;
            pend_hue   <= '0;
            pend_burst <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            if (frame_end_c && pend_valid) begin
                lines_live <= pend_lines;
                hue_live   <= pend_hue;
                burst_live <= pend_burst;
                pend_valid <= 1'b0;
                ready_q    <= 1'b1;
            end
            if (transfer_c) begin
                pend_lines <= lines_clamped_c;
                pend_hue   <= cfg.cfg_hue;
                pend_burst <= cfg.cfg_burst_en;
                pend_valid <= 1'b1;
                ready_q    <= 1'b0;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_n      <= 1'b1;
            burst_gate  <= 1'b0;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            select      <= '0;
            line_num    <= '0;
        end else begin
            sync_n      <= !sync_low_c;
            burst_gate  <= burst_c;
            active      <= active_c;
            line_start  <= (h_count == '0);
            frame_start <= (h_count == '0) && (v_count == '0);
            select      <= active_c ? PW'(color_phase + hue_live) : '0;
            line_num    <= v_count;
        end
    end
endmodule
